// File: rtl/me_best_mv_sel_if.sv
// Handshake and data bundle for me_best_mv_sel.
// Parameters: SAD_W (SAD lane width), MV_W (signed MV component width).
// Signals:
//   start, sad_valid, SAD16x16    : search input side (SAD16x16 = 4 lanes).
//   out_valid, out_ready, out_idx : winner handshake to mode decision.
//   out_mv_x, out_mv_y, out_sad   : winner data.
//   busy, done                    : window status.
// Modports: master = producer/consumer side, slave = me_best_mv_sel.
interface me_best_mv_sel_if #(
    parameter int SAD_W = 16,
    parameter int MV_W  = 7
);
    logic                    start;
    logic                    sad_valid;
    logic [4*SAD_W-1:0]      SAD16x16;
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              out_idx;
    logic signed [MV_W-1:0]  out_mv_x;
    logic signed [MV_W-1:0]  out_mv_y;
    logic [SAD_W-1:0]        out_sad;
    logic                    done;

    modport master (
        output start, sad_valid, SAD16x16, out_ready,
        input  busy, out_valid, out_idx,
        input  out_mv_x, out_mv_y, out_sad, done
    );

    modport slave (
        input  start, sad_valid, SAD16x16, out_ready,
        output busy, out_valid, out_idx,
        output out_mv_x, out_mv_y, out_sad, done
    );
endinterface

// File: rtl/me_best_mv_sel.sv
// Per-partition best-MV tracker for one integer ME search window.
// Ports: clk, rst_n (async active-low), bus (me_best_mv_sel_if.slave).
// Optional macro ME_MV_COST_EN: metric = SAD + LAMBDA*(|mvx|+|mvy|),
// saturated to SAD_W bits; otherwise metric = SAD.
module me_best_mv_sel #(
    parameter int SR     = 32,
    parameter int SAD_W  = 16,
    parameter int MV_W   = 7,
    parameter int LAMBDA = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    me_best_mv_sel_if.slave   bus
);
    localparam logic signed [MV_W-1:0] MV_LO = MV_W'(-SR);
    localparam logic signed [MV_W-1:0] MV_HI = MV_W'(SR - 1);
    localparam logic [SAD_W-1:0]       SAD_MAX = '1;

    typedef enum logic [1:0] {IDLE, SEARCH, OUTPUT} state_t;

    state_t                 state;
    logic signed [MV_W-1:0] mv_x, mv_y;
    logic [SAD_W-1:0]       min_q [4];
    logic signed [MV_W-1:0] bx_q  [4];
    logic signed [MV_W-1:0] by_q  [4];

    logic [SAD_W-1:0]       metric [4];
    logic [SAD_W-1:0]       nmin   [4];
    logic signed [MV_W-1:0] nbx    [4];
    logic signed [MV_W-1:0] nby    [4];
    logic                   last_pos;
    logic [1:0]             nidx;

`ifdef ME_MV_COST_EN
    localparam int CW = SAD_W + 8;
    logic [MV_W-1:0] ax, ay;
    logic [CW-1:0]   cost;
    logic [CW-1:0]   wide [4];

    always_comb begin
        ax = mv_x[MV_W-1] ? MV_W'(-mv_x) : MV_W'(mv_x);
        ay = mv_y[MV_W-1] ? MV_W'(-mv_y) : MV_W'(mv_y);
        cost = CW'(LAMBDA) * (CW'(ax) + CW'(ay));
        for (int i = 0; i < 4; i++) begin
            wide[i] = CW'(bus.SAD16x16[i*SAD_W +: SAD_W]) + cost;
            metric[i] = (|wide[i][CW-1:SAD_W]) ? SAD_MAX
                                               : wide[i][SAD_W-1:0];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            metric[i] = bus.SAD16x16[i*SAD_W +: SAD_W];
        end
    end
`endif

    // Strict less-than keeps the earliest raster position on ties.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (metric[i] < min_q[i]) begin
                nmin[i] = metric[i];
                nbx[i]  = mv_x;
                nby[i]  = mv_y;
            end else begin
                nmin[i] = min_q[i];
                nbx[i]  = bx_q[i];
                nby[i]  = by_q[i];
            end
        end
    end

    assign last_pos = (mv_x == MV_HI) && (mv_y == MV_HI);
    assign nidx     = bus.out_idx + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mv_x          <= MV_LO;
            mv_y          <= MV_LO;
            for (int i = 0; i < 4; i++) begin
                min_q[i] <= SAD_MAX;
                bx_q[i]  <= '0;
                by_q[i]  <= '0;
            end
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b0;
            bus.out_idx   <= 2'd0;
            bus.out_mv_x  <= '0;
            bus.out_mv_y  <= '0;
            bus.out_sad   <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= SEARCH;
                        bus.busy <= 1'b1;
                        mv_x     <= MV_LO;
                        mv_y     <= MV_LO;
                        for (int i = 0; i < 4; i++) begin
                            min_q[i] <= SAD_MAX;
                            bx_q[i]  <= '0;
                            by_q[i]  <= '0;
                        end
                    end
                end
                SEARCH: begin
                    if (bus.sad_valid) begin
                        for (int i = 0; i < 4; i++) begin
                            min_q[i] <= nmin[i];
                            bx_q[i]  <= nbx[i];
                            by_q[i]  <= nby[i];
                        end
                        if (last_pos) begin
                            mv_x          <= MV_LO;
                            mv_y          <= MV_LO;
                            state         <= OUTPUT;
                            bus.out_valid <= 1'b1;
                            bus.out_idx   <= 2'd0;
                            // Lane 0 may improve on this very beat.
                            bus.out_mv_x  <= nbx[0];
                            bus.out_mv_y  <= nby[0];
                            bus.out_sad   <= nmin[0];
                        end else if (mv_x == MV_HI) begin
                            mv_x <= MV_LO;
                            mv_y <= mv_y + MV_W'(1);
                        end else begin
                            mv_x <= mv_x + MV_W'(1);
                        end
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        if (bus.out_idx == 2'd3) begin
                            state         <= IDLE;
                            bus.out_valid <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                            bus.out_idx   <= 2'd0;
                        end else begin
                            bus.out_idx   <= nidx;
                            bus.out_mv_x  <= bx_q[nidx];
                            bus.out_mv_y  <= by_q[nidx];
                            bus.out_sad   <= min_q[nidx];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_me_best_mv_sel.sv
// Directed table-driven bench for me_best_mv_sel at SR=2.
// Expected winners are hand-computed per build (with/without ME_MV_COST_EN).
module tb_me_best_mv_sel;
    localparam int SR     = 2;
    localparam int SAD_W  = 16;
    localparam int MV_W   = 7;
    localparam int LAMBDA = 4;
    localparam int NPOS   = 4 * SR * SR;
    localparam int NVEC   = 4;

    typedef struct {
        int base [4];
        int s1l, s1x, s1y, s1v;
        int s2l, s2x, s2y, s2v;
        int ex [4];
        int ey [4];
        int es [4];
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    me_best_mv_sel_if #(.SAD_W(SAD_W), .MV_W(MV_W)) bus ();

    me_best_mv_sel #(
        .SR(SR), .SAD_W(SAD_W), .MV_W(MV_W), .LAMBDA(LAMBDA)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always @(posedge clk) if (bus.done) done_cnt <= done_cnt + 1;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", n, act, exp);
        end
    endtask

    function automatic int sad_at(input vec_t v, input int l,
                                  input int x, input int y);
        if (l == v.s1l && x == v.s1x && y == v.s1y) return v.s1v;
        if (l == v.s2l && x == v.s2x && y == v.s2y) return v.s2v;
        return v.base[l];
    endfunction

    task automatic drive_pos(input vec_t v, input int p);
        int x, y;
        x = (p % (2 * SR)) - SR;
        y = (p / (2 * SR)) - SR;
        for (int l = 0; l < 4; l++)
            bus.SAD16x16[l*SAD_W +: SAD_W] = SAD_W'(sad_at(v, l, x, y));
    endtask

    task automatic collect(input vec_t v, input int stall, input string t);
        for (int k = 0; k < 4; k++) begin
            int w;
            w = 0;
            while (!bus.out_valid && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            chk({t, "_valid"}, int'(bus.out_valid), 1);
            chk({t, "_idx"}, int'(bus.out_idx), k);
            chk({t, "_mvx"}, int'(bus.out_mv_x), v.ex[k]);
            chk({t, "_mvy"}, int'(bus.out_mv_y), v.ey[k]);
            chk({t, "_sad"}, int'(bus.out_sad), v.es[k]);
            if (k == stall) begin
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk({t, "_hold_v"}, int'(bus.out_valid), 1);
                    chk({t, "_hold_i"}, int'(bus.out_idx), k);
                    chk({t, "_hold_x"}, int'(bus.out_mv_x), v.ex[k]);
                    chk({t, "_hold_y"}, int'(bus.out_mv_y), v.ey[k]);
                    chk({t, "_hold_s"}, int'(bus.out_sad), v.es[k]);
                    chk({t, "_hold_d"}, int'(bus.done), 0);
                end
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic run_window(input vec_t v, input bit noise,
                              input int stall, input string t);
        int d0;
        d0 = done_cnt;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({t, "_busy"}, int'(bus.busy), 1);
        for (int p = 0; p < NPOS; p++) begin
            if (noise && p == 7) begin
                @(posedge clk); #1;
            end
            drive_pos(v, p);
            bus.sad_valid = 1'b1;
            if (noise && p == 3) bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.sad_valid = 1'b0;
            if (p == NPOS - 2)
                chk({t, "_early"}, int'(bus.out_valid), 0);
        end
        chk({t, "_lat"}, int'(bus.out_valid), 1);
        collect(v, stall, t);
        chk({t, "_done"}, int'(bus.done), 1);
        chk({t, "_idle"}, int'(bus.busy), 0);
        @(posedge clk); #1;
        chk({t, "_pulse"}, int'(bus.done), 0);
        chk({t, "_ndone"}, done_cnt - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout act=1 exp=0");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0].base = '{100, 100, 100, 100};
        vecs[0].s1l = 0; vecs[0].s1x = 1; vecs[0].s1y = -2;
        vecs[0].s1v = 7;
        vecs[0].s2l = -1; vecs[0].s2x = 0; vecs[0].s2y = 0;
        vecs[0].s2v = 0;
        vecs[1].base = '{100, 100, 60, 100};
        vecs[1].s1l = 2; vecs[1].s1x = -1; vecs[1].s1y = -2;
        vecs[1].s1v = 50;
        vecs[1].s2l = 2; vecs[1].s2x = 0; vecs[1].s2y = 1;
        vecs[1].s2v = 50;
        vecs[2].base = '{100, 200, 100, 100};
        vecs[2].s1l = 1; vecs[2].s1x = 0; vecs[2].s1y = 0;
        vecs[2].s1v = 20;
        vecs[2].s2l = 1; vecs[2].s2x = -2; vecs[2].s2y = -2;
        vecs[2].s2v = 14;
        vecs[3].base = '{65535, 100, 100, 100};
        vecs[3].s1l = 3; vecs[3].s1x = 1; vecs[3].s1y = 1;
        vecs[3].s1v = 0;
        vecs[3].s2l = -1; vecs[3].s2x = 0; vecs[3].s2y = 0;
        vecs[3].s2v = 0;
`ifdef ME_MV_COST_EN
        vecs[0].ex = '{1, 0, 0, 0};
        vecs[0].ey = '{-2, 0, 0, 0};
        vecs[0].es = '{19, 100, 100, 100};
        vecs[1].ex = '{0, 0, 0, 0};
        vecs[1].ey = '{0, 0, 1, 0};
        vecs[1].es = '{100, 100, 54, 100};
        vecs[2].ex = '{0, 0, 0, 0};
        vecs[2].ey = '{0, 0, 0, 0};
        vecs[2].es = '{100, 20, 100, 100};
        vecs[3].ex = '{0, 0, 0, 1};
        vecs[3].ey = '{0, 0, 0, 1};
        vecs[3].es = '{65535, 100, 100, 8};
`else
        vecs[0].ex = '{1, -2, -2, -2};
        vecs[0].ey = '{-2, -2, -2, -2};
        vecs[0].es = '{7, 100, 100, 100};
        vecs[1].ex = '{-2, -2, -1, -2};
        vecs[1].ey = '{-2, -2, -2, -2};
        vecs[1].es = '{100, 100, 50, 100};
        vecs[2].ex = '{-2, -2, -2, -2};
        vecs[2].ey = '{-2, -2, -2, -2};
        vecs[2].es = '{100, 14, 100, 100};
        vecs[3].ex = '{0, -2, -2, 1};
        vecs[3].ey = '{0, -2, -2, 1};
        vecs[3].es = '{65535, 100, 100, 0};
`endif

        bus.start = 1'b0;
        bus.sad_valid = 1'b0;
        bus.SAD16x16 = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_idx", int'(bus.out_idx), 0);
        chk("rst_sad", int'(bus.out_sad), 0);
        chk("rst_mvx", int'(bus.out_mv_x), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++)
            run_window(vecs[i], 1'b0, -1, $sformatf("vec%0d", i));

        run_window(vecs[0], 1'b0, 1, "bp");

        bus.SAD16x16 = '0;
        bus.sad_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("ign_busy", int'(bus.busy), 0);
        end
        bus.sad_valid = 1'b0;
        run_window(vecs[2], 1'b1, -1, "ign");

        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.SAD16x16 = {4{16'd1}};
        bus.sad_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.sad_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", int'(bus.busy), 0);
        chk("mid_valid", int'(bus.out_valid), 0);
        chk("mid_idx", int'(bus.out_idx), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_window(vecs[0], 1'b0, -1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
